// File: rtl/if_pkg.sv
// Shared types and constants for the MINIRISC-V instruction fetch stage.
package if_pkg;

    localparam int IF_DATAWIDTH = 32;
    localparam int IF_QDEPTH    = 2;

    localparam logic [IF_DATAWIDTH-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [IF_DATAWIDTH-1:0] pc;
        logic [IF_DATAWIDTH-1:0] instr;
        logic                    fault;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue.sv
// Small synchronous FIFO with push/pop/clear and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int  DEPTH   = IF_QDEPTH,
    parameter type entry_t = fetch_entry_t,
    localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_i,
    input  logic          push_i,
    input  entry_t        push_data_i,
    input  logic          pop_i,
    output entry_t        head_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full queue is allowed only when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (do_push && !do_pop) begin
                count_d = count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push && !clear_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: credit-limited imem requests, response queue, flush/kill.
// Optional macro IF_MISALIGN_CHECK_EN turns misaligned PCs into fault entries.
module if_fetch_stage
    import if_pkg::*;
#(
    parameter int DATAWIDTH = IF_DATAWIDTH,
    parameter int QDEPTH    = IF_QDEPTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATAWIDTH-1:0] pc_in,
    output logic                 pc_advance,
    input  logic                 flush,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [DATAWIDTH-1:0] imem_addr,
    input  logic                 imem_resp_valid,
    input  logic [DATAWIDTH-1:0] imem_resp_data,
    output logic                 id_valid,
    input  logic                 id_ready,
    output logic [DATAWIDTH-1:0] id_pc,
    output logic [DATAWIDTH-1:0] id_instr,
    output logic                 id_fault
);

    localparam int CW = $clog2(QDEPTH + 1);

    fetch_entry_t         q_head;
    fetch_entry_t         q_push_data;
    logic                 q_push, q_pop, q_full, q_empty;
    logic [CW-1:0]        q_count;

    logic [DATAWIDTH-1:0] tag_head;
    logic                 tag_full, tag_empty;
    logic [CW-1:0]        tag_count;

    logic [CW-1:0]        outstanding_q, outstanding_d;
    logic [CW-1:0]        kill_q, kill_d;
    logic [CW:0]          in_use;
    logic                 credit;
    logic                 misaligned;
    logic                 misalign_push;
    logic                 req_fire;
    logic                 resp_drop;
    logic                 resp_accept;

    // Queue slots plus requests in flight (including killed ones) bound new requests.
    assign in_use = {1'b0, q_count} + {1'b0, outstanding_q};
    assign credit = (in_use < (CW+1)'(QDEPTH));

`ifdef IF_MISALIGN_CHECK_EN
    assign misaligned    = (pc_in[1:0] != 2'b00);
    // Waiting for in-flight responses keeps the fault entry in program order.
    assign misalign_push = !flush && credit && misaligned && (outstanding_q == '0);
`else
    assign misaligned    = 1'b0;
    assign misalign_push = 1'b0;
`endif

    assign imem_req_valid = !flush && credit && !misaligned;
    assign imem_addr      = pc_in;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign pc_advance     = req_fire || misalign_push;

    assign resp_drop   = imem_resp_valid && (kill_q != '0);
    assign resp_accept = imem_resp_valid && (kill_q == '0) && !flush;

    assign q_push = resp_accept || misalign_push;
    assign q_pop  = id_valid && id_ready;

    always_comb begin
        q_push_data = '{pc: tag_head, instr: imem_resp_data, fault: 1'b0};
        if (misalign_push) begin
            q_push_data = '{pc: pc_in, instr: NOP_INSTR, fault: 1'b1};
        end
    end

    always_comb begin
        outstanding_d = outstanding_q;
        kill_d        = kill_q;
        if (req_fire) begin
            outstanding_d = outstanding_d + CW'(1);
        end
        if (imem_resp_valid && (outstanding_q != '0)) begin
            outstanding_d = outstanding_d - CW'(1);
        end
        // Everything still in flight after a flush belongs to the old path.
        if (flush) begin
            kill_d = outstanding_d;
        end else if (resp_drop) begin
            kill_d = kill_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_q <= '0;
            kill_q        <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            kill_q        <= kill_d;
        end
    end

    if_fetch_queue #(
        .DEPTH   (QDEPTH),
        .entry_t (fetch_entry_t)
    ) u_instr_q (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (flush),
        .push_i      (q_push),
        .push_data_i (q_push_data),
        .pop_i       (q_pop),
        .head_o      (q_head),
        .count_o     (q_count),
        .full_o      (q_full),
        .empty_o     (q_empty)
    );

    if_fetch_queue #(
        .DEPTH   (QDEPTH),
        .entry_t (logic [DATAWIDTH-1:0])
    ) u_tag_q (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (flush),
        .push_i      (req_fire),
        .push_data_i (pc_in),
        .pop_i       (resp_accept),
        .head_o      (tag_head),
        .count_o     (tag_count),
        .full_o      (tag_full),
        .empty_o     (tag_empty)
    );

    assign id_valid = !q_empty;
    assign id_pc    = q_head.pc;
    assign id_instr = q_head.instr;
    assign id_fault = q_head.fault;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(q_push && q_full && !q_pop));
    a_tag_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(resp_accept && tag_empty));
    a_tag_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(req_fire && tag_full));
    a_spurious_resp: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_resp_valid && (outstanding_q == '0)));
    a_tag_tracks: assert property (@(posedge clk) disable iff (!rst_n)
        (({1'b0, tag_count} + {1'b0, kill_q}) == {1'b0, outstanding_q}));

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed table, corner sequences, random run vs model.
module tb_if_fetch_stage;
    import if_pkg::*;

    localparam int QD = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_in = '0;
    logic        pc_advance;
    logic        flush = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_fault;

    always #5 clk = ~clk;

    if_fetch_stage #(.DATAWIDTH(32), .QDEPTH(QD)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_in           (pc_in),
        .pc_advance      (pc_advance),
        .flush           (flush),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_pc           (id_pc),
        .id_instr        (id_instr),
        .id_fault        (id_fault)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], 16'hC0DE} ^ 32'h5A5A_0000;
    endfunction

    // ---------------- behavioural model: program-order queue + memory pipe
    typedef struct { logic [31:0] pc; bit arrived; } live_t;
    typedef struct { logic [31:0] addr; int due; bit dead; } mem_t;

    live_t       live[$];
    mem_t        memq[$];
    logic [31:0] pc_m;
    int          cyc, lat, last_due;
    bit          o_adv, o_idv;
    logic [31:0] o_idpc;

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
        imem_resp_data = '0; id_ready = 1'b0; pc_in = '0;
        live.delete(); memq.delete();
        pc_m = '0; cyc = 0; last_due = -1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pc_advance", pc_advance, 0);
        chk("rst_id_valid", id_valid, 0);
        chk("rst_id_pc", id_pc, 0);
        chk("rst_id_instr", id_instr, 0);
        chk("rst_id_fault", id_fault, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input bit fl, input logic [31:0] tgt, input bit rdy, input bit idr);
        bit resp, e_rv, e_adv, e_idv;
        int dead_n, due;
        @(negedge clk);
        resp = (memq.size() > 0) && (memq[0].due <= cyc);
        pc_in = pc_m; flush = fl; imem_req_ready = rdy; id_ready = idr;
        imem_resp_valid = resp;
        imem_resp_data  = resp ? instr_of(memq[0].addr) : 32'h0;
        dead_n = 0;
        foreach (memq[i]) if (memq[i].dead) dead_n++;
        e_rv  = !fl && ((live.size() + dead_n) < QD);
        e_adv = e_rv && rdy;
        e_idv = (live.size() > 0) && live[0].arrived;
        #1;
        chk("req_valid", imem_req_valid, e_rv);
        chk("pc_advance", pc_advance, e_adv);
        chk("imem_addr", imem_addr, pc_m);
        chk("id_valid", id_valid, e_idv);
        if (e_idv) begin
            chk("id_pc", id_pc, live[0].pc);
            chk("id_instr", id_instr, instr_of(live[0].pc));
            chk("id_fault", id_fault, 0);
        end
        o_adv = pc_advance; o_idv = id_valid; o_idpc = id_pc;
        if (resp) begin
            if (!memq[0].dead && !fl) begin
                for (int i = 0; i < live.size(); i++) begin
                    if (!live[i].arrived) begin
                        live[i].arrived = 1'b1;
                        break;
                    end
                end
            end
            void'(memq.pop_front());
        end
        if (e_idv && idr) void'(live.pop_front());
        if (e_adv) begin
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            live.push_back('{pc: pc_m, arrived: 1'b0});
            memq.push_back('{addr: pc_m, due: due, dead: 1'b0});
            last_due = due;
            pc_m = pc_m + 32'd4;
        end
        if (fl) begin
            live.delete();
            foreach (memq[i]) memq[i].dead = 1'b1;
            pc_m = tgt;
        end
        cyc++;
    endtask

    // ---------------- directed vector table (1-cycle memory, decode always ready)
    typedef struct {
        logic [31:0] pc; bit rdy; bit rv; logic [31:0] rdata; bit idr;
        bit e_rv; bit e_adv; bit e_idv; logic [31:0] e_pc; logic [31:0] e_instr;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] pc, input bit rdy, input bit rv,
                                input logic [31:0] rdata, input bit e_rv, input bit e_adv,
                                input bit e_idv, input logic [31:0] e_pc);
        vec_t v;
        v.pc = pc; v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.idr = 1'b1;
        v.e_rv = e_rv; v.e_adv = e_adv; v.e_idv = e_idv;
        v.e_pc = e_pc; v.e_instr = instr_of(e_pc);
        return v;
    endfunction

    initial begin
        vec_t tbl[9];
        int   adv_cnt;
        bit   seen;

        tbl[0] = mk(32'h00, 1, 0, 32'h0,           1, 1, 0, 32'h00);
        tbl[1] = mk(32'h04, 1, 1, instr_of(32'h00), 1, 1, 0, 32'h00);
        tbl[2] = mk(32'h08, 1, 1, instr_of(32'h04), 0, 0, 1, 32'h00);
        tbl[3] = mk(32'h08, 1, 0, 32'h0,           1, 1, 1, 32'h04);
        tbl[4] = mk(32'h0C, 1, 1, instr_of(32'h08), 1, 1, 0, 32'h00);
        tbl[5] = mk(32'h10, 1, 1, instr_of(32'h0C), 0, 0, 1, 32'h08);
        tbl[6] = mk(32'h10, 1, 0, 32'h0,           1, 1, 1, 32'h0C);
        tbl[7] = mk(32'h14, 0, 1, instr_of(32'h10), 1, 0, 0, 32'h00);
        tbl[8] = mk(32'h14, 0, 0, 32'h0,           1, 0, 1, 32'h10);

        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            pc_in = tbl[i].pc; imem_req_ready = tbl[i].rdy; flush = 1'b0;
            imem_resp_valid = tbl[i].rv; imem_resp_data = tbl[i].rdata; id_ready = tbl[i].idr;
            #1;
            chk("tbl_req_valid", imem_req_valid, tbl[i].e_rv);
            chk("tbl_pc_advance", pc_advance, tbl[i].e_adv);
            chk("tbl_imem_addr", imem_addr, tbl[i].pc);
            chk("tbl_id_valid", id_valid, tbl[i].e_idv);
            if (tbl[i].e_idv) begin
                chk("tbl_id_pc", id_pc, tbl[i].e_pc);
                chk("tbl_id_instr", id_instr, tbl[i].e_instr);
            end
        end

        // decode stalled for 5 cycles: queue fills, requests stop, head holds
        do_reset(); lat = 1; adv_cnt = 0;
        repeat (5) begin
            step(0, 0, 1, 0);
            adv_cnt += int'(o_adv);
        end
        chk("stall_accepts", adv_cnt, 2);
        chk("stall_req_valid", imem_req_valid, 0);
        chk("stall_head_pc", id_pc, 32'h0);
        repeat (8) step(0, 0, 1, 1);

        // memory back-pressure for 3 cycles
        repeat (3) step(0, 0, 0, 1);
        repeat (6) step(0, 0, 1, 1);

        // flush with two requests in flight under 3-cycle memory
        do_reset(); lat = 3;
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        step(1, 32'h100, 1, 1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(0, 0, 1, 1);
            if (o_idv) begin
                seen = 1'b1;
                chk("flush_redirect_pc", o_idpc, 32'h100);
            end
        end
        if (!seen) chk("flush_redirect_timeout", 0, 1);

        // flush coinciding with a response and a dequeue
        do_reset(); lat = 1;
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        step(1, 32'h200, 1, 1);
        step(0, 0, 0, 1);
        chk("flush_same_cycle_empty", o_idv, 0);
        repeat (6) step(0, 0, 1, 1);

`ifdef IF_MISALIGN_CHECK_EN
        do_reset();
        @(negedge clk);
        pc_in = 32'h2; imem_req_ready = 1'b1; id_ready = 1'b0;
        #1;
        chk("mis_req_valid", imem_req_valid, 0);
        chk("mis_pc_advance", pc_advance, 1);
        @(negedge clk);
        pc_in = 32'h4; imem_req_ready = 1'b0;
        #1;
        chk("mis_id_valid", id_valid, 1);
        chk("mis_id_pc", id_pc, 32'h2);
        chk("mis_id_instr", id_instr, 32'h00000013);
        chk("mis_id_fault", id_fault, 1);
`endif

        // randomized traffic against the model
        for (int r = 0; r < 4; r++) begin
            do_reset();
            lat = 1 + (r % 3);
            repeat (400) begin
                step(($urandom % 16) == 0, $urandom & 32'h0000_0FFC,
                     ($urandom % 4) != 0, ($urandom % 3) != 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
